// File: rtl/rob_multiwrite_regfile.sv
// ============================================================================
// Module      : rob_multiwrite_regfile
// Description : Multi-write, multi-read register file with per-entry valid
//               bits, same-cycle write forwarding, flush and collision flag.
//               Optional macro ROB_CONFLICT_COUNT_EN adds a saturating
//               collision counter on conflict_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_multiwrite_regfile #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 16,
  parameter int WR_PORTS   = 3,
  parameter int RD_PORTS   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WR_PORTS-1:0]            wr_en,
  input  logic [WR_PORTS*ADDR_WIDTH-1:0] wr_addr,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic [RD_PORTS-1:0]            rd_en,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [RD_PORTS-1:0]            rd_valid,
  input  logic                           flush,
  output logic                           wr_conflict,
  output logic [15:0]                    conflict_cnt
);

  localparam int c_depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [c_depth];
  logic [c_depth-1:0]    r_valid;
  logic [c_depth-1:0]    w_hit;
  logic [DATA_WIDTH-1:0] w_wdata [c_depth];
  logic                  w_conflict;
  logic                  r_conflict;

  // Per-entry winner: scanning from the highest port down lets the lowest
  // matching port overwrite the selection last.
  always_comb begin
    w_hit = '0;
    for (int e = 0; e < c_depth; e++) begin
      w_wdata[e] = '0;
      for (int i = WR_PORTS - 1; i >= 0; i--) begin
        if (wr_en[i] && (wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(e))) begin
          w_hit[e]   = 1'b1;
          w_wdata[e] = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < WR_PORTS; i++) begin
      for (int k = i + 1; k < WR_PORTS; k++) begin
        if (wr_en[i] && wr_en[k] &&
            (wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
          w_conflict = 1'b1;
        end
      end
    end
  end

  // Flush wins over a same-cycle write for the valid bit; data still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < c_depth; e++) begin
        r_mem[e] <= '0;
      end
      r_valid    <= '0;
      r_conflict <= 1'b0;
    end else begin
      for (int e = 0; e < c_depth; e++) begin
        if (w_hit[e]) begin
          r_mem[e] <= w_wdata[e];
        end
      end
      r_valid    <= flush ? '0 : (r_valid | w_hit);
      r_conflict <= w_conflict;
    end
  end

  assign wr_conflict = r_conflict;

  generate
    for (genvar j = 0; j < RD_PORTS; j++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_ra;
      logic [DATA_WIDTH-1:0] r_q;
      logic                  r_v;

      assign w_ra = rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
          r_v <= 1'b0;
        end else if (rd_en[j]) begin
          r_q <= w_hit[w_ra] ? w_wdata[w_ra] : r_mem[w_ra];
          r_v <= !flush && (w_hit[w_ra] || r_valid[w_ra]);
        end
      end

      assign rd_data[j*DATA_WIDTH +: DATA_WIDTH] = r_q;
      assign rd_valid[j]                         = r_v;
    end
  endgenerate

`ifdef ROB_CONFLICT_COUNT_EN
  logic [15:0] r_cnt;

  // One count per colliding cycle regardless of how many ports collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_conflict && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign conflict_cnt = r_cnt;
`else
  assign conflict_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rob_multiwrite_regfile.sv
// ============================================================================
// Module      : tb_rob_multiwrite_regfile
// Description : Scoreboard bench for rob_multiwrite_regfile with a
//               behavioural model; honours ROB_CONFLICT_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rob_multiwrite_regfile;

  localparam int AW    = 3;
  localparam int DW    = 16;
  localparam int WP    = 3;
  localparam int RP    = 2;
  localparam int DEPTH = 8;

  logic              clk;
  logic              rst_n;
  logic [WP-1:0]     wr_en;
  logic [WP*AW-1:0]  wr_addr;
  logic [WP*DW-1:0]  wr_data;
  logic [RP-1:0]     rd_en;
  logic [RP*AW-1:0]  rd_addr;
  logic [RP*DW-1:0]  rd_data;
  logic [RP-1:0]     rd_valid;
  logic              flush;
  logic              wr_conflict;
  logic [15:0]       conflict_cnt;

  rob_multiwrite_regfile #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WR_PORTS(WP), .RD_PORTS(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .flush(flush), .wr_conflict(wr_conflict), .conflict_cnt(conflict_cnt)
  );

  typedef struct packed {
    logic [RP*DW-1:0] d;
    logic [RP-1:0]    v;
    logic             c;
    logic [15:0]      n;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state
  logic [DW-1:0]    m_data [DEPTH];
  bit               m_valid[DEPTH];
  logic [RP*DW-1:0] m_rd;
  logic [RP-1:0]    m_rv;
  int               m_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < DEPTH; e++) begin
      m_data[e]  = '0;
      m_valid[e] = 0;
    end
    m_rd  = '0;
    m_rv  = '0;
    m_cnt = 0;
  endtask

  // Drive one cycle, predict the post-edge outputs, queue the prediction.
  task automatic step(input logic [WP-1:0] en, input logic [WP*AW-1:0] wa,
                      input logic [WP*DW-1:0] wd, input logic [RP-1:0] re,
                      input logic [RP*AW-1:0] ra, input logic fl);
    exp_t          e;
    bit            written[DEPTH];
    logic [DW-1:0] wv[DEPTH];
    int            hits[DEPTH];
    bit            coll;
    int            a;
    @(negedge clk);
    wr_en = en; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; flush = fl;
    for (int k = 0; k < DEPTH; k++) begin
      written[k] = 0; hits[k] = 0; wv[k] = '0;
    end
    for (int i = 0; i < WP; i++) begin
      if (en[i]) begin
        a = int'(wa[i*AW +: AW]);
        hits[a]++;
        if (!written[a]) begin
          written[a] = 1;
          wv[a]      = wd[i*DW +: DW];
        end
      end
    end
    coll = 0;
    for (int k = 0; k < DEPTH; k++) if (hits[k] >= 2) coll = 1;
    for (int j = 0; j < RP; j++) begin
      if (re[j]) begin
        a = int'(ra[j*AW +: AW]);
        m_rd[j*DW +: DW] = written[a] ? wv[a] : m_data[a];
        m_rv[j]          = !fl && (written[a] || m_valid[a]);
      end
    end
`ifdef ROB_CONFLICT_COUNT_EN
    if (coll && m_cnt < 65535) m_cnt++;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if (written[k]) m_data[k] = wv[k];
      m_valid[k] = fl ? 0 : (m_valid[k] || written[k]);
    end
    e.d = m_rd; e.v = m_rv; e.c = coll; e.n = 16'(m_cnt);
    @(posedge clk);
    q.push_back(e);
  endtask

  task automatic idle();
    step('0, '0, '0, '0, '0, 1'b0);
  endtask

  // Monitor: registered outputs are stable by the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        me = q.pop_front();
        chk("sb_rd_data", 64'(rd_data), 64'(me.d));
        chk("sb_rd_valid", 64'(rd_valid), 64'(me.v));
        chk("sb_wr_conflict", 64'(wr_conflict), 64'(me.c));
        chk("sb_conflict_cnt", 64'(conflict_cnt), 64'(me.n));
      end
    end
  end

  initial begin
    logic [15:0] cnt_req;
    logic [2:0]  a;
    rst_n = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0; flush = 1'b0;
    model_reset();
    #1;
    chk("reset_rd_data", 64'(rd_data), 64'd0);
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_conflict", 64'(wr_conflict), 64'd0);
    chk("reset_cnt", 64'(conflict_cnt), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Three distinct writes, then read them back
    step(3'b111, {3'd7, 3'd4, 3'd1}, {16'h0033, 16'h0022, 16'h0011}, 2'b00, '0, 1'b0);
    #1 chk("distinct_no_conflict", 64'(wr_conflict), 64'd0);
    step('0, '0, '0, 2'b11, {3'd4, 3'd1}, 1'b0);
    #1 chk("distinct_rd_data", 64'(rd_data), 64'h0022_0011);
    chk("distinct_rd_valid", 64'(rd_valid), 64'd3);
    step('0, '0, '0, 2'b01, {3'd0, 3'd7}, 1'b0);
    #1 chk("distinct_rd7", 64'(rd_data[15:0]), 64'h0033);

    // Collision: port 1 beats port 2
    step(3'b110, {3'd5, 3'd5, 3'd0}, {16'hBBBB, 16'hAAAA, 16'h0000}, 2'b00, '0, 1'b0);
    #1 chk("collide_flag", 64'(wr_conflict), 64'd1);
`ifdef ROB_CONFLICT_COUNT_EN
    cnt_req = 16'd1;
`else
    cnt_req = 16'd0;
`endif
    chk("collide_cnt", 64'(conflict_cnt), 64'(cnt_req));
    step('0, '0, '0, 2'b01, {3'd0, 3'd5}, 1'b0);
    #1 chk("collide_flag_drop", 64'(wr_conflict), 64'd0);
    chk("collide_winner", 64'(rd_data[15:0]), 64'hAAAA);

    // Same-cycle forwarding on read port 1
    step(3'b001, {3'd0, 3'd0, 3'd3}, {16'h0, 16'h0, 16'h1234}, 2'b10, {3'd3, 3'd0}, 1'b0);
    #1 chk("fwd_data", 64'(rd_data[31:16]), 64'h1234);
    chk("fwd_valid", 64'(rd_valid[1]), 64'd1);

    // Flush with concurrent write
    step(3'b001, {3'd0, 3'd0, 3'd2}, {16'h0, 16'h0, 16'h5555}, 2'b00, '0, 1'b1);
    step('0, '0, '0, 2'b11, {3'd2, 3'd2}, 1'b0);
    #1 chk("flush_data", 64'(rd_data), 64'h5555_5555);
    chk("flush_valid", 64'(rd_valid), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(WP'($urandom), (WP*AW)'($urandom), (WP*DW)'({$urandom, $urandom}),
           RP'($urandom), (RP*AW)'($urandom), ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset between edges during a write
    @(negedge clk);
    wr_en = 3'b111; wr_addr = 9'o123; wr_data = 48'hFEED_BEEF_CAFE; rd_en = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rd_data", 64'(rd_data), 64'd0);
    chk("async_rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("async_rst_conflict", 64'(wr_conflict), 64'd0);
    chk("async_rst_cnt", 64'(conflict_cnt), 64'd0);
    model_reset();
    wr_en = '0; rd_en = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < DEPTH; k += 2) begin
      step('0, '0, '0, 2'b11, {3'(k + 1), 3'(k)}, 1'b0);
      #1 chk("post_rst_valid", 64'(rd_valid), 64'd0);
    end

    // Long run of collisions to reach counter saturation
    for (int n = 0; n < 65540; n++) begin
      a = 3'($urandom);
      step(3'b011, {3'd0, a, a}, (WP*DW)'({$urandom, $urandom}),
           RP'($urandom), (RP*AW)'($urandom), 1'b0);
    end
`ifdef ROB_CONFLICT_COUNT_EN
    cnt_req = 16'hFFFF;
`else
    cnt_req = 16'd0;
`endif
    #1 chk("sat_cnt", 64'(conflict_cnt), 64'(cnt_req));

    idle();
    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
